// File: rtl/bitblade_pkg.sv
// Shared types and default constants for the BitBlade shift accumulator.
// Saturation is selected at build time with the BITBLADE_ACC_SAT_EN macro.
package bitblade_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_LANES   = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_SHIFT_W = 4;
    localparam int LANE_W      = 2;
    localparam int MAX_SHIFT   = 14;

endpackage

// File: rtl/bitblade_lane_reduce.sv
// Combinational lane reduction: signed adder tree over 2-bit lanes, or the
// XNOR-binary form 2*popcount - LANES, selected by bin_i.
module bitblade_lane_reduce
    import bitblade_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int SUM_W = $clog2(LANES) + 2
) (
    input  logic [LANE_W*LANES-1:0] mul_i,
    input  logic                    bin_i,
    output logic [SUM_W-1:0]        red_o
);

    localparam logic [SUM_W-1:0] LANES_V = SUM_W'(LANES);

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] pop;

    always_comb begin
        sum = '0;
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + {{(SUM_W-2){mul_i[2*k+1]}}, mul_i[2*k +: 2]};
            pop = pop + SUM_W'(mul_i[2*k]);
        end
    end

    // Binary lanes encode +1/-1 as 1/0, so the sum is 2*P - LANES.
    assign red_o = bin_i ? ((pop << 1) - LANES_V) : sum;

endmodule

// File: rtl/bitblade_shift_accumulator.sv
// Shift-accumulate stage for BitBlade lane products; one signed result per
// dot product. Define BITBLADE_ACC_SAT_EN for saturating adds and out_ovf.
module bitblade_shift_accumulator
    import bitblade_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANE_W*LANES-1:0] in_mul,
    input  logic [SHIFT_W-1:0]      in_shift,
    input  logic                    in_bin,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf,
    output logic [1:0]              dbg_state_o
);

    localparam int SUM_W = $clog2(LANES) + 2;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and out_data holds while stalled.
    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             bin_q, bin_d;

    logic             eff_bin;
    logic [SUM_W-1:0] red;
    logic [ACC_W-1:0] red_ext;
    logic [ACC_W-1:0] contrib;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;

    // The mode is taken live on the first beat, then from the latched copy.
    assign eff_bin = (state_q == IDLE) ? in_bin : bin_q;

    bitblade_lane_reduce #(
        .LANES(LANES),
        .SUM_W(SUM_W)
    ) u_reduce (
        .mul_i(in_mul),
        .bin_i(eff_bin),
        .red_o(red)
    );

    assign red_ext = {{(ACC_W-SUM_W){red[SUM_W-1]}}, red};
    assign contrib = eff_bin ? red_ext : (red_ext << in_shift);
    assign base    = (state_q == ACC) ? acc_q : '0;

`ifdef BITBLADE_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_sum;
    logic           ovf_q, ovf_d;

    assign wide_sum = {base[ACC_W-1], base} + {contrib[ACC_W-1], contrib};
    assign add_ovf  = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    assign acc_sum  = !add_ovf ? wide_sum[ACC_W-1:0]
                    : (wide_sum[ACC_W] ? ACC_MIN : ACC_MAX);
    assign out_ovf  = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    always_comb begin
        ovf_d = ovf_q;
        case (state_q)
            IDLE:    if (in_valid) ovf_d = add_ovf;
            ACC:     if (in_valid) ovf_d = ovf_q | add_ovf;
            HOLD:    if (out_ready) ovf_d = 1'b0;
            default: ovf_d = 1'b0;
        endcase
    end
`else
    assign add_ovf = 1'b0;
    assign acc_sum = base + contrib;
    assign out_ovf = add_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            bin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_valid && in_ready && !eff_bin)
            assert (int'(in_shift) <= MAX_SHIFT);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: if (in_valid) begin
                acc_d   = acc_sum;
                bin_d   = in_bin;
                state_d = in_last ? HOLD : ACC;
            end
            ACC: if (in_valid) begin
                acc_d   = acc_sum;
                state_d = in_last ? HOLD : ACC;
            end
            HOLD: if (out_ready) begin
                acc_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q != HOLD);
    assign out_valid   = (state_q == HOLD);
    assign out_data    = acc_q;
    assign dbg_state_o = state_q;

endmodule
